// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM: Moore decode of datapath controls from state,
// with the PC load enable also qualified by the ALU zero flag for branches.
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_ld,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [3:0] state
);
    localparam int unsigned OPC_W = 6;
    localparam int unsigned ST_W  = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [ST_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEM_ADR = 4'd2,
        MEM_RD  = 4'd3,
        MEM_WB  = 4'd4,
        MEM_WR  = 4'd5,
        R_EX    = 4'd6,
        R_WB    = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        JAL     = 4'd10,
        JR      = 4'd11,
        I_EX    = 4'd12,
        I_WB    = 4'd13
    } state_t;

    state_t state_q, state_d;
    logic   pc_write, branch, is_bne;
    logic   ir_write_s, reg_write_s, mem_write_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d     = state_q;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_ctrl    = ALU_AND;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                ir_write_s = 1'b1;
                alu_src_b  = 2'b01;
                alu_ctrl   = ALU_ADD;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opc)
                    OP_LW, OP_SW:      state_d = MEM_ADR;
                    OP_RTYPE:          state_d = (func == FN_JR) ? JR : R_EX;
                    OP_BEQ, OP_BNE:    state_d = BRANCH;
                    OP_J:              state_d = JUMP;
                    OP_JAL:            state_d = JAL;
                    OP_ADDI, OP_SLTI:  state_d = I_EX;
                    default:           state_d = FETCH;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opc == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = MEM_WB;
            end
            MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 2'b01;
                state_d     = FETCH;
            end
            MEM_WR: begin
                i_or_d      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = FETCH;
            end
            R_EX: begin
                alu_src_a = 1'b1;
                case (func)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
                state_d = R_WB;
            end
            R_WB: begin
                reg_write_s = 1'b1;
                reg_dst     = 2'b01;
                state_d     = FETCH;
            end
            I_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = I_WB;
            end
            I_WB: begin
                reg_write_s = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = FETCH;
            end
            JAL: begin
                pc_write    = 1'b1;
                pc_src      = 2'b10;
                reg_write_s = 1'b1;
                reg_dst     = 2'b10;
                mem_to_reg  = 2'b10;
                state_d     = FETCH;
            end
            JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables held low while reset is asserted, even though reset parks us in FETCH
    assign is_bne    = (opc == OP_BNE);
    assign pc_ld     = ~rst & (pc_write | (branch & (zero ^ is_bne)));
    assign ir_write  = ~rst & ir_write_s;
    assign reg_write = ~rst & reg_write_s;
    assign mem_write = ~rst & mem_write_s;
    assign state     = ST_W'(state_q);

endmodule
